// File: rtl/s2p_pkg.sv
// s2p_pkg: shared types and constants for the serial-to-parallel receiver.
//   state_t     receiver FSM states
//   DATA_BITS   payload bits per frame
//   FRAME_BITS  start + data + stop bits on the line
//   START_BIT / STOP_BIT  line levels of the framing bits
package s2p_pkg;

    localparam int   DATA_BITS  = 8;
    localparam int   FRAME_BITS = 10;
    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous bit.
//   clk    destination clock
//   reset  synchronous, active-high; both flops load RESET_VAL
//   d      asynchronous input
//   q      synchronized output (2 clk latency)
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/s2p_rx.sv
// s2p_rx: oversampling async serial receiver (start 0, 8 data MSB first, stop 1).
//   clk            system clock
//   reset          synchronous, active-high
//   sample_tick    enable at OVERSAMPLE x bit rate (may be held high)
//   serial_in      asynchronous line, idle high
//   parallel_out   last good byte, held between frames
//   data_valid     1-clk pulse: parallel_out updated
//   framing_error  1-clk pulse: stop bit sampled low
//   rx_busy        high whenever the FSM is not idle
module s2p_rx #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sample_tick,
    input  logic                 serial_in,
    output logic [DATA_BITS-1:0] parallel_out,
    output logic                 data_valid,
    output logic                 framing_error,
    output logic                 rx_busy
);

    import s2p_pkg::*;

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(OVERSAMPLE - 1);
    localparam logic [2:0]       IDX_LAST = 3'(DATA_BITS - 1);

    logic rx_s;

    sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (serial_in),
        .q     (rx_s)
    );

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [2:0]             idx_q, idx_d;
    logic [DATA_BITS-1:0]   shreg_q, shreg_d;
    logic [DATA_BITS-1:0]   pout_q, pout_d;
    logic                   valid_q, valid_d;
    logic                   ferr_q, ferr_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        pout_d  = pout_q;
        // Pulses are cleared on every clk, tick or not.
        valid_d = 1'b0;
        ferr_d  = 1'b0;

        if (sample_tick) begin
            unique case (state_q)
                IDLE: begin
                    if (rx_s == START_BIT) begin
                        state_d = START;
                        cnt_d   = '0;
                    end
                end
                START: begin
                    if (cnt_q == CNT_HALF) begin
                        cnt_d = '0;
                        idx_d = '0;
                        // A start bit that is gone by mid-bit was a glitch.
                        state_d = (rx_s == START_BIT) ? DATA : IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (cnt_q == CNT_FULL) begin
                        cnt_d   = '0;
                        shreg_d = {shreg_q[DATA_BITS-2:0], rx_s};
                        if (idx_q == IDX_LAST) begin
                            idx_d   = '0;
                            state_d = STOP;
                        end else begin
                            idx_d = idx_q + 3'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (cnt_q == CNT_FULL) begin
                        cnt_d = '0;
                        if (rx_s == STOP_BIT) begin
                            pout_d  = shreg_q;
                            valid_d = 1'b1;
                            state_d = IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = BREAK;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                BREAK: begin
                    // Hold off until the line returns high so a stuck-low
                    // line is not mistaken for a fresh start bit.
                    if (rx_s == STOP_BIT) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            pout_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            pout_q  <= pout_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    assign parallel_out  = pout_q;
    assign data_valid    = valid_q;
    assign framing_error = ferr_q;
    assign rx_busy       = (state_q != IDLE);

endmodule

// File: doc/s2p_rx.md
# s2p_rx

Serial-to-parallel receiver for the team's 10-bit async serial link. Frame: idle-high line, one start bit (0), 8 data bits MSB first, one stop bit (1). The block sits at the far end of the link from the parallel-to-serial transmitter. It oversamples the line on a strobe, recovers each byte, and presents it as a one-cycle valid pulse, with framing-error reporting.

## Interface
Parameters:
- OVERSAMPLE, 16: sample_tick pulses per bit period; even, ≥4.
- DATA_BITS, 8: payload bits per frame. Fixed at 8 for this link.

Ports:
- clk  in  1  system clock
- reset  in  1  reset, synchronous, active-high; clock clk
- sample_tick  in  1  single-cycle enable at OVERSAMPLE × bit rate; may be held high continuously
- serial_in  in  1  asynchronous line input, idle high
- parallel_out  out  8  last good byte; holds between frames
- data_valid  out  1  one-cycle pulse: parallel_out updated this cycle
- framing_error  out  1  one-cycle pulse: stop bit sampled 0
- rx_busy  out  1  high in any state other than IDLE

## Operation
- serial_in passes through a 2-flop synchronizer (flops reset to 1). All decisions use the synchronized value `rx_s`.
- State and counter updates happen only on clk edges where sample_tick=1. Exception: data_valid and framing_error clear on the next clk regardless of tick.
- Tick counter: $clog2(OVERSAMPLE) bits, wraps at OVERSAMPLE-1. Bit index: 3 bits.
- States:
  - IDLE: on a tick with rx_s=0, go to START with cnt=0.
  - START: count ticks. At cnt=OVERSAMPLE/2-1 (mid start bit):
    - rx_s=0: go to DATA with cnt=0, idx=0.
    - rx_s=1: glitch; go to IDLE, with no output pulse.
  - DATA: at cnt=OVERSAMPLE-1 (mid-bit), sample and shift: shreg <= {shreg[6:0], rx_s}. Then idx++ and cnt=0. After the sample at idx=7, go to STOP.
  - STOP: at cnt=OVERSAMPLE-1, sample:
    - rx_s=1: parallel_out <= shreg, data_valid=1, go to IDLE.
    - rx_s=0: framing_error=1, parallel_out unchanged, go to BREAK.
  - BREAK: wait for a tick with rx_s=1, then go to IDLE. This prevents a held-low line from being read as a new start bit.
- Simultaneous events: reset overrides everything.
- Reset mid-frame: abort to IDLE. No valid or error pulse. shreg is discarded.

## Timing
- Reset values:
  - parallel_out=8'h00, data_valid=0, framing_error=0, rx_busy=0
  - state=IDLE, cnt=0, idx=0, shreg=0, synchronizer flops=1
- Input latency: 2 clk from serial_in to rx_s.
- Output timing: data_valid / framing_error are registered. They assert on the clk after the edge that takes the stop-bit tick, and stay high exactly 1 clk.
- Frame duration: start edge to valid ≈ 9.5 bit periods (OVERSAMPLE/2 + 9·OVERSAMPLE ticks) + 3 clk.
- Back-to-back frames: the next start bit may begin immediately after the stop bit. The receiver is back in IDLE half a bit before the stop bit ends.
- rx_busy is combinational from state.

## Structure
- Package `s2p_pkg`:
  - state enum {IDLE, START, DATA, STOP, BREAK}
  - DATA_BITS=8, FRAME_BITS=10
  - START_BIT=1'b0, STOP_BIT=1'b1
- Sub-module `sync_2ff`: 2-flop synchronizer with a reset value parameter. It is reusable elsewhere in the design.
- The FSM, counters, and shift register live in `s2p_rx`.

## Test plan
- Frame 0xB5 (line sequence 0,1,0,1,1,0,1,0,1,1) with OVERSAMPLE=16, sample_tick every 4 clk -> exactly one data_valid pulse, parallel_out=8'hB5, framing_error never high.
- Back-to-back frames 0xB5 then 0x8D with no idle gap -> two data_valid pulses, parallel_out=8'hB5 then 8'h8D.
- Line low for 3 ticks, then high -> no pulses, state returns to IDLE, rx_busy falls, parallel_out unchanged.
- Frame 0x3C with stop bit 0, line held low 20 ticks, then high, then frame 0x11 -> framing_error pulse once, parallel_out stays at its previous value, then a data_valid pulse with 8'h11.
- Reset asserted at data bit 4 of frame 0xFF, then released with line idle -> no pulses, all outputs at reset values. A following 0x5A frame is received correctly.
- sample_tick held high continuously, frame 0x01 -> parallel_out=8'h01, data_valid pulse is exactly 1 clk wide.
